tx_resp_ctrl: RTL and testbench

//  Downstream companion of the RX command controller. Captures results the command path

---
 rtl/sys_ctrl_pkg.sv | 19 +
 rtl/resp_byte_shifter.sv | 37 +++
 rtl/tx_resp_ctrl.sv | 108 ++++++++++
 tb/tb_tx_resp_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: response FSM states, default
// datapath widths and the command opcodes understood by the RX command side.
package sys_ctrl_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ALU_OUT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } resp_state_e;

    localparam logic [7:0] CMD_RF_WR     = 8'hAA;
    localparam logic [7:0] CMD_RF_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPER  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOPER = 8'hDD;

endpackage

// File: rtl/resp_byte_shifter.sv
// Holding register plus remaining-byte counter for one captured response.
// Presents the low byte and shifts the next byte down on each accepted transfer.
module resp_byte_shifter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int CNT_W         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [ALU_OUT_WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0]         load_count,
    input  logic                     shift,
    output logic [DATA_WIDTH-1:0]    byte_out,
    output logic                     empty
);

    logic [ALU_OUT_WIDTH-1:0] hold;
    logic [CNT_W-1:0]         rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            rem  <= '0;
        end else if (load) begin
            hold <= load_data;
            rem  <= load_count;
        end else if (shift) begin
            hold <= hold >> DATA_WIDTH;
            rem  <= rem - CNT_W'(1);
        end
    end

    assign byte_out = hold[DATA_WIDTH-1:0];
    assign empty    = (rem == '0);

endmodule

// File: rtl/tx_resp_ctrl.sv
// Captures register-read and ALU results and feeds them LSB byte first into the
// UART transmitter over a VALID/BUSY handshake; drops strobes arriving while busy.
module tx_resp_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ALU_OUT_WIDTH = ALU_OUT_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_Valid,
    input  logic                     TX_Busy,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     RESP_BUSY,
    output logic                     OVERRUN,
    output resp_state_e              dbg_state
);

    localparam int ALU_BYTES = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int CNT_W     = $clog2(ALU_BYTES) + 1;

    generate
        if (ALU_OUT_WIDTH % DATA_WIDTH != 0) begin : g_width_check
            $error("tx_resp_ctrl: ALU_OUT_WIDTH must be a multiple of DATA_WIDTH");
        end
    endgenerate

    // Handshake: TX_D_VLD stays high with TX_P_DATA stable until TX_Busy is
    // sampled high (byte taken); the next byte is offered only after TX_Busy
    // is sampled low again.
    resp_state_e              state, next_state;
    logic                     load, shift, empty, ovr_nxt;
    logic [ALU_OUT_WIDTH-1:0] load_data;
    logic [CNT_W-1:0]         load_count;

    resp_byte_shifter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ALU_OUT_WIDTH(ALU_OUT_WIDTH),
        .CNT_W        (CNT_W)
    ) u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .load      (load),
        .load_data (load_data),
        .load_count(load_count),
        .shift     (shift),
        .byte_out  (TX_P_DATA),
        .empty     (empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            TX_D_VLD  <= 1'b0;
            RESP_BUSY <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= next_state;
            TX_D_VLD  <= (next_state == ST_SEND);
            RESP_BUSY <= (next_state != ST_IDLE);
            OVERRUN   <= ovr_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (ALU_OUT_Valid || RdData_Valid) next_state = ST_SEND;
            ST_SEND:      if (TX_Busy) next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!TX_Busy) next_state = empty ? ST_IDLE : ST_SEND;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        shift      = 1'b0;
        load_data  = ALU_OUT_WIDTH'(RdData);
        load_count = CNT_W'(1);
        ovr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                // ALU result takes priority; a simultaneous read is the dropped one
                if (ALU_OUT_Valid) begin
                    load       = 1'b1;
                    load_data  = ALU_OUT;
                    load_count = CNT_W'(ALU_BYTES);
                    ovr_nxt    = RdData_Valid;
                end else if (RdData_Valid) begin
                    load = 1'b1;
                end
            end
            ST_SEND: begin
                shift   = TX_Busy;
                ovr_nxt = ALU_OUT_Valid || RdData_Valid;
            end
            ST_WAIT_DONE: ovr_nxt = ALU_OUT_Valid || RdData_Valid;
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_tx_resp_ctrl.sv
// Bench for tx_resp_ctrl: directed response scenarios, a UART busy mimic, and a
// byte-queue model compared against the DUT outputs every cycle.
module tb_tx_resp_ctrl;
    import sys_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NB = AW / DW;

    logic          CLK, RST;
    logic [DW-1:0] RdData;
    logic          RdData_Valid;
    logic [AW-1:0] ALU_OUT;
    logic          ALU_OUT_Valid;
    logic          TX_Busy;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD, RESP_BUSY, OVERRUN;
    resp_state_e   dbg_state;

    tx_resp_ctrl #(.DATA_WIDTH(DW), .ALU_OUT_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST), .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid), .TX_Busy(TX_Busy),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .RESP_BUSY(RESP_BUSY),
        .OVERRUN(OVERRUN), .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // UART mimic: takes a byte and stays busy for 10 cycles
    logic uart_en;
    int   uart_cnt;
    initial begin
        TX_Busy  = 1'b0;
        uart_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                TX_Busy  = 1'b0;
                uart_cnt = 0;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) TX_Busy = 1'b0;
            end else if (uart_en && TX_D_VLD) begin
                TX_Busy  = 1'b1;
                uart_cnt = 10;
            end
        end
    end

    // model: pending bytes of the current response in exp_q
    logic [DW-1:0] exp_q[$];
    logic m_busy, m_vld, m_fly, m_ovr;

    always @(posedge CLK or posedge RST) begin : model
        logic          was_busy;
        logic [AW-1:0] w;
        if (RST) begin
            exp_q.delete();
            m_busy = 0; m_vld = 0; m_fly = 0; m_ovr = 0;
        end else begin
            was_busy = m_busy;
            if (m_vld) begin
                if (TX_Busy) begin
                    void'(exp_q.pop_front());
                    m_vld = 0;
                    m_fly = 1;
                end
            end else if (m_fly && !TX_Busy) begin
                m_fly = 0;
                if (exp_q.size() > 0) m_vld = 1;
                else m_busy = 0;
            end
            if (was_busy) begin
                m_ovr = ALU_OUT_Valid || RdData_Valid;
            end else if (ALU_OUT_Valid) begin
                w = ALU_OUT;
                for (int i = 0; i < NB; i++) exp_q.push_back(w[i*DW +: DW]);
                m_busy = 1; m_vld = 1; m_ovr = RdData_Valid;
            end else if (RdData_Valid) begin
                exp_q.push_back(RdData);
                m_busy = 1; m_vld = 1; m_ovr = 0;
            end else begin
                m_ovr = 0;
            end
        end
    end

    // scoreboard: every cycle out of reset
    always @(negedge CLK) begin
        if (!RST) begin
            check("tx_d_vld", {31'd0, TX_D_VLD}, {31'd0, m_vld});
            check("resp_busy", {31'd0, RESP_BUSY}, {31'd0, m_busy});
            check("overrun", {31'd0, OVERRUN}, {31'd0, m_ovr});
            if (m_vld && exp_q.size() > 0)
                check("tx_p_data", {24'd0, TX_P_DATA}, {24'd0, exp_q[0]});
        end
    end

    // log of bytes actually handed over, and overrun pulse count
    logic [DW-1:0] got_q[$];
    int ovr_cnt;
    always @(posedge CLK) if (!RST && TX_D_VLD && TX_Busy) got_q.push_back(TX_P_DATA);
    always @(negedge CLK) if (!RST && OVERRUN) ovr_cnt++;

    // driver tasks
    task automatic strobe(input logic rd_v, input logic [DW-1:0] rd, input logic alu_v, input logic [AW-1:0] alu);
        @(posedge CLK); #1;
        RdData = rd; RdData_Valid = rd_v; ALU_OUT = alu; ALU_OUT_Valid = alu_v;
        @(posedge CLK); #1;
        RdData_Valid = 1'b0; ALU_OUT_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge CLK);
            if (!RESP_BUSY && !m_busy && !TX_Busy) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_log(input string name, input int n, input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        check({name, "_count"}, got_q.size(), n);
        if (got_q.size() > 0) check({name, "_b0"}, {24'd0, got_q[0]}, {24'd0, b0});
        if (n > 1 && got_q.size() > 1) check({name, "_b1"}, {24'd0, got_q[1]}, {24'd0, b1});
    endtask

    task automatic new_test();
        got_q.delete();
        ovr_cnt = 0;
    endtask

    initial begin
        logic ok;
        RST = 1'b1; RdData = '0; RdData_Valid = 0; ALU_OUT = '0; ALU_OUT_Valid = 0;
        uart_en = 1'b1; ovr_cnt = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_vld", {31'd0, TX_D_VLD}, 32'd0);
        check("rst_busy", {31'd0, RESP_BUSY}, 32'd0);
        check("rst_ovr", {31'd0, OVERRUN}, 32'd0);
        check("rst_data", {24'd0, TX_P_DATA}, 32'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // 1: single read byte, latency 1
        new_test();
        strobe(1'b1, 8'h5A, 1'b0, '0);
        check("t1_latency_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("t1_first_data", {24'd0, TX_P_DATA}, 32'h5A);
        wait_idle("t1_idle");
        check_log("t1", 1, 8'h5A, 8'h00);
        check("t1_ovr_cnt", ovr_cnt, 0);

        // 2: ALU result, LSB byte first
        new_test();
        strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
        check("t2_first_data", {24'd0, TX_P_DATA}, 32'hEF);
        wait_idle("t2_idle");
        check_log("t2", 2, 8'hEF, 8'hBE);
        check("t2_ovr_cnt", ovr_cnt, 0);

        // 3: collision, ALU wins
        new_test();
        strobe(1'b1, 8'hAA, 1'b1, 16'h1234);
        check("t3_ovr_pulse", {31'd0, OVERRUN}, 32'd1);
        wait_idle("t3_idle");
        check_log("t3", 2, 8'h34, 8'h12);
        check("t3_ovr_cnt", ovr_cnt, 1);

        // 4: read strobe while busy is dropped
        new_test();
        strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
        repeat (4) @(posedge CLK);
        strobe(1'b1, 8'h99, 1'b0, '0);
        wait_idle("t4_idle");
        check_log("t4", 2, 8'hEF, 8'hBE);
        check("t4_ovr_cnt", ovr_cnt, 1);

        // 5: reset while second byte is on offer
        new_test();
        strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (got_q.size() == 1 && TX_D_VLD) ok = 1'b1;
        end
        check("t5_reach_byte2", {31'd0, ok}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("t5_rst_vld", {31'd0, TX_D_VLD}, 32'd0);
        check("t5_rst_busy", {31'd0, RESP_BUSY}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        new_test();
        strobe(1'b1, 8'h77, 1'b0, '0);
        wait_idle("t5_idle");
        check_log("t5", 1, 8'h77, 8'h00);

        // 6: TX_Busy held low, offer must stay put
        new_test();
        uart_en = 1'b0;
        strobe(1'b1, 8'hC3, 1'b0, '0);
        repeat (50) @(posedge CLK);
        #1;
        check("t6_stall_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("t6_stall_data", {24'd0, TX_P_DATA}, 32'hC3);
        check("t6_stall_busy", {31'd0, RESP_BUSY}, 32'd1);
        uart_en = 1'b1;
        wait_idle("t6_idle");
        check_log("t6", 1, 8'hC3, 8'h00);

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
